// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Defines the load-queue entry bundle, default sizes and a one-hot helper.
package wb_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int DW_P      = 32;
    localparam int AW_P      = 5;
    localparam int CNT_W     = $clog2(DEPTH_DEF) + 1;

    typedef struct packed {
        logic            live;
        logic [AW_P-1:0] rd;
        logic [DW_P-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [AW_P-1:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular load-return queue with parallel kill-by-rd and busy-mask reduction.
// Ports: Clk, Reset (async, active-high); i_push/i_push_entry enqueue at tail;
//   i_pop drops the head; i_kill/i_kill_rd clear live on every entry with that
//   rd; o_head is the current head; o_full/o_empty; o_busy_mask is the OR of
//   one-hot rd over live entries, bit 0 forced low.
// Callers must not push when full nor pop when empty.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CNT_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            i_push,
    input  wb_entry_t       i_push_entry,
    input  logic            i_pop,
    input  logic            i_kill,
    input  logic [AW_P-1:0] i_kill_rd,
    output wb_entry_t       o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [31:0]     o_busy_mask
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [31:0]       w_mask;

    // Popped slots have their live bit cleared, so unoccupied slots never
    // contribute to the busy mask and no occupancy check is needed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].rd == i_kill_rd) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (i_pop) begin
                r_mem[r_rd_ptr].live <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                w_mask = w_mask | rd_onehot(r_mem[i].rd);
            end
        end
        w_mask[0] = 1'b0;
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_busy_mask = w_mask;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller for the single register-file write port: merges ALU
// results with queued load returns and retires at most one write per cycle.
// Ports: Clk, Reset (async, active-high); alu_valid/alu_rd/alu_data (never
//   stalled); ld_valid/ld_ready/ld_rd/ld_data load-return handshake;
//   RD/WData/RegWr registered write port; busy_mask of pending live loads.
// Option: define WB_BYPASS_EN to let a load write directly when the queue is
//   empty and the ALU idle (1-cycle latency instead of 2).
module reg_wb_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_P,
    parameter int AW    = AW_P
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic [AW-1:0] RD,
    output logic [DW-1:0] WData,
    output logic          RegWr,
    output logic [31:0]   busy_mask
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     w_head;
    wb_entry_t     w_push_entry;
    logic          w_full;
    logic          w_empty;
    logic          w_ld_acc;
    logic          w_pop;
    logic          w_byp;
    logic          w_push;
    logic          r_wr;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_data;

    assign ld_ready = !w_full;
    assign w_ld_acc = ld_valid && !w_full;

    // ALU owns the slot; otherwise the oldest queued load drains first.
    assign w_pop = !alu_valid && !w_empty;

`ifdef WB_BYPASS_EN
    assign w_byp = !alu_valid && w_empty && w_ld_acc;
`else
    assign w_byp = 1'b0;
`endif

    assign w_push = w_ld_acc && !w_byp;

    // A coincident ALU write to the same rd is younger, so the incoming load
    // is queued already dead; loads to x0 are queued dead as well.
    always_comb begin
        w_push_entry.live = (ld_rd != '0) &&
                            !(alu_valid && alu_rd == ld_rd);
        w_push_entry.rd   = ld_rd;
        w_push_entry.data = ld_data;
    end

    wb_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill       (alu_valid),
        .i_kill_rd    (alu_rd),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_busy_mask  (busy_mask)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (alu_valid) begin
            r_wr   <= (alu_rd != '0);
            r_rd   <= alu_rd;
            r_data <= alu_data;
        end else if (w_pop) begin
            // A killed head still consumes this slot, with no write.
            r_wr   <= w_head.live;
            r_rd   <= w_head.rd;
            r_data <= w_head.data;
        end else if (w_byp) begin
            r_wr   <= (ld_rd != '0);
            r_rd   <= ld_rd;
            r_data <= ld_data;
        end else begin
            r_wr   <= 1'b0;
        end
    end

    assign RegWr = r_wr;
    assign RD    = r_rd;
    assign WData = r_data;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: directed scenarios plus random traffic
// checked against a queue-level model of the write-back rules.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [4:0]  RD;
    logic [31:0] WData;
    logic        RegWr;
    logic [31:0] busy_mask;

    reg_wb_ctrl #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .RD        (RD),
        .WData     (WData),
        .RegWr     (RegWr),
        .busy_mask (busy_mask)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ld_t;

    typedef struct {
        bit          wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } ex_t;

    ld_t mq[$];
    ex_t exq[$];
    ex_t mon_e;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock of stimulus: check model-visible state, drive at the falling
    // edge, advance the model, then release inputs just after the rising edge.
    task automatic step(input bit av, input logic [4:0] ard,
                        input logic [31:0] ad, input bit lv,
                        input logic [4:0] lrd, input logic [31:0] ld);
        bit  acc;
        bit  live_in;
        ex_t e;
        ld_t h;
        @(negedge Clk);
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, mq.size() < DEPTH});
        chk("busy_mask", busy_mask, model_mask());
        acc       = lv && (mq.size() < DEPTH);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = acc;
        ld_rd     = lrd;
        ld_data   = ld;
        e         = '{1'b0, 5'd0, 32'd0};
        live_in   = (lrd != 5'd0);
        if (av) begin
            if (ard != 5'd0) e = '{1'b1, ard, ad};
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
            if (lrd == ard) live_in = 1'b0;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.live) e = '{1'b1, h.rd, h.data};
        end else if (BYP && acc) begin
            if (lrd != 5'd0) e = '{1'b1, lrd, ld};
            acc = 1'b0;
        end
        if (acc) mq.push_back('{lrd, ld, live_in});
        exq.push_back(e);
        @(posedge Clk);
        #2;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        mq.delete();
        exq.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: one expected slot per stimulated cycle, exact-cycle timing.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (exq.size() > 0) begin
                mon_e = exq.pop_front();
                chk("RegWr", {31'd0, RegWr}, {31'd0, mon_e.wr});
                if (mon_e.wr) begin
                    chk("RD", {27'd0, RD}, {27'd0, mon_e.rd});
                    chk("WData", WData, mon_e.data);
                end
            end else begin
                chk("RegWr_idle", {31'd0, RegWr}, 32'd0);
            end
        end
    end

    always @(posedge Clk) begin
        if (!Reset && ld_valid && !ld_ready) begin
            miscompares++;
            $display("FAIL protocol: ld_valid offered with ld_ready=0");
        end
    end

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_RegWr", {31'd0, RegWr}, 32'd0);
        chk("rst_RD", {27'd0, RD}, 32'd0);
        chk("rst_WData", WData, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_busy", busy_mask, 32'd0);

        // ALU write latency
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("alu_RegWr", {31'd0, RegWr}, 32'd1);
        chk("alu_RD", {27'd0, RD}, 32'd5);
        chk("alu_WData", WData, 32'hDEADBEEF);

        // Load from idle, empty queue
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
`ifdef WB_BYPASS_EN
        chk("byp_RegWr", {31'd0, RegWr}, 32'd1);
        chk("byp_RD", {27'd0, RD}, 32'd7);
`else
        chk("q1_RegWr", {31'd0, RegWr}, 32'd0);
        idle();
        chk("q2_RegWr", {31'd0, RegWr}, 32'd1);
        chk("q2_RD", {27'd0, RD}, 32'd7);
`endif
        chk("ld7_WData", WData, 32'h1234);
        idle();

        // Fill queue under continuous ALU traffic
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(1 + i),
                 32'(200 + i));
        chk("full_ready", {31'd0, ld_ready}, 32'd0);
        chk("full_busy", busy_mask, 32'h1E);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("drain_RD", {27'd0, RD}, 32'(1 + i));
            chk("drain_WData", WData, 32'(200 + i));
        end
        chk("drain_busy", busy_mask, 32'd0);

        // Kill of a queued load by a younger ALU write
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h55);
        chk("kill_busy9", busy_mask, 32'h200);
        step(1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'd0);
        chk("kill_busy", busy_mask, 32'd0);
        idle();
        chk("kill_pop_RegWr", {31'd0, RegWr}, 32'd0);

        // x0 from both sources
        step(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        chk("x0_RegWr", {31'd0, RegWr}, 32'd0);
        idle();
        chk("x0_pop_RegWr", {31'd0, RegWr}, 32'd0);
        idle();

        // Reset with three queued entries
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(1 + i), 32'(i));
        chk("pre_rst_busy", busy_mask, 32'h0E);
        do_reset();
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_ready", {31'd0, ld_ready}, 32'd1);
        repeat (4) idle();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            step(($urandom_range(0, 9) < 5),
                 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (DEPTH + 2) idle();
        chk("end_busy", busy_mask, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
# reg_wb_ctrl

Write-back controller that drives the single write port of the 32x32 register file. It merges single-cycle ALU results with variable-latency load returns, queues loads when the port is busy, and retires at most one register write per cycle. It also exports a busy mask of destination registers with pending load results, which hazard logic uses to detect read-after-write conflicts.

## Interface
Parameters:
- DEPTH, 4: load-return queue entries (power of two, >= 2)
- DW, 32: data width
- AW, 5: register address width

Ports:
- Clk  in  1  clock
- Reset  in  1  reset; asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; cannot be stalled
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_valid  in  1  load return offered
- ld_ready  out  1  load return accepted when ld_valid && ld_ready
- ld_rd  in  AW  load destination register
- ld_data  in  DW  load data
- RD  out  AW  register file write address (registered)
- WData  out  DW  register file write data (registered)
- RegWr  out  1  register file write enable (registered)
- busy_mask  out  32  bit r = 1: live queued load targets register r; bit 0 is always 0

## Operation
- Each cycle selects at most one write source. Priority order: ALU, then the queue head, then a bypassed incoming load.
- ALU: when alu_valid=1, the write issues with RD=alu_rd and WData=alu_data.
- Queue drain: when alu_valid=0 and the queue is non-empty, the head is popped. A live head writes. A killed head pops with RegWr=0 and uses up that cycle's slot.
- Bypass (WB_BYPASS_EN): when alu_valid=0, the queue is empty and a load is accepted, the load writes directly and takes no queue entry.
- Otherwise an accepted load is pushed at the tail with live=1.
- Kill: an ALU write to register r clears the live bit of every queue entry with rd==r. This includes an entry pushed in the same cycle. Loads are always older than a coincident ALU result, so a stale load never overwrites a newer value.
- x0: any write with rd==0 produces RegWr=0. A load to x0 is still accepted, and it is queued as killed.
- ld_ready = (count < DEPTH). A push and pop in the same cycle keep the count unchanged. Offering ld_valid while ld_ready=0 is a protocol violation; the bench asserts on it.
- busy_mask = OR over live entries of a one-hot decode of rd, with bit 0 forced to 0. The mask is combinational from queue state.

## Timing
- Reset values: RegWr=0, RD=0, WData=0, queue empty, count=0, ld_ready=1, busy_mask=0.
- Reset asserted mid-operation discards every queued entry. No write issues during Reset.
- ALU latency: alu_valid in cycle n gives RegWr=1 in cycle n+1.
- Load latency:
  - Bypass: 1 cycle.
  - Queued, with no ALU activity: 2 cycles (push in cycle n, pop in cycle n+1, RegWr in cycle n+2).
  - Each ALU cycle delays the drain by one cycle.
- Queue pointers wrap modulo DEPTH. Full means count==DEPTH. Empty means count==0.
- busy_mask updates the cycle after a push or kill. A popped entry's bit clears in the same cycle its write is registered.
- When alu_valid is held high continuously, the queue does not drain. This is accepted behaviour; upstream guarantees idle cycles.

## Configuration
- Macro: WB_BYPASS_EN.
- When defined, a load arriving with the queue empty and the ALU idle writes in 1 cycle.
- When undefined, every load passes through the queue, with a minimum latency of 2 cycles. In that case a load pushed to an empty queue while alu_valid=0 never writes in the same slot.
- Ordering and kill semantics are identical either way.

## Structure
- Shared package wb_pkg:
  - DEPTH default
  - typedef wb_entry_t {live, rd[AW], data[DW]}
  - localparam for count width, $clog2(DEPTH)+1
- Sub-module wb_queue: circular buffer of wb_entry_t with push, pop, a kill-by-rd port that clears matching live bits in parallel, and a busy-mask reduction.
- The top level contains the source select, bypass and output registers.

## Test plan
- Reset → RegWr=0, RD=0, WData=0, ld_ready=1, busy_mask=0. Assert Reset mid-queue with 3 entries → queue empty, no write issues.
- alu_valid with rd=5 and data=0xDEADBEEF → next cycle RegWr=1, RD=5, WData=0xDEADBEEF.
- Load rd=7 data=0x1234 arrives with ALU idle and queue empty → RegWr at +1 cycle with bypass, or at +2 cycles with the macro undefined.
- Four loads (rd=1..4) arrive under continuous ALU writes → ld_ready=0 and busy_mask=0x1E. After the ALU goes idle, writes retire in order 1, 2, 3, 4 and busy_mask returns to 0.
- Queued load rd=9, then ALU write rd=9 data=0xAA → register 9 is written only with 0xAA. The killed entry pops with RegWr=0, and busy_mask bit 9 clears.
- ALU write rd=0 and load rd=0 → RegWr never asserts; the load is accepted and popped.
